// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the VGA raster generator. The defaults describe
// the 640x480 @ 60 Hz mode driven from a 25 MHz pixel rate. The package also
// provides a small range-test helper that the sync decoders use.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   // Coordinate width; both axis totals must fit in this many bits.
   localparam int COORD_W = 10;

   // Horizontal defaults, in pixels.
   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   // Vertical defaults, in lines.
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   // Derived default totals and sync windows (inclusive bounds).
   localparam int H_TOTAL_DEF    = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF    = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
   localparam int H_SYNC_END_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF - 1;
   localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
   localparam int V_SYNC_END_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF - 1;

   // True when lo <= v <= hi.
   function automatic logic in_range(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_if
// Raster timing bundle produced by vga_sync_gen and consumed by the renderer.
//   p_tick      pixel enable, high every second system clock
//   hsync/vsync sync pulses, polarity chosen by the generator
//   video_on    current coordinate lies in the visible area
//   pixel_x/y   current raster coordinate
//   frame_start one-cycle pulse when the raster wraps to (0,0)
// master: the timing generator (drives everything)
// slave : a consumer (reads everything)
// -----------------------------------------------------------------------------
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic               p_tick;
   logic               hsync;
   logic               vsync;
   logic               video_on;
   logic [COORD_W-1:0] pixel_x;
   logic [COORD_W-1:0] pixel_y;
   logic               frame_start;

   modport master (
      output p_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
   );

   modport slave (
      input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Modulo-TOTAL counter for one raster axis.
//   clk50M     system clock
//   reset      synchronous, active-high
//   en         advance by one on this edge
//   count      registered count, 0..TOTAL-1
//   count_next value count takes on the coming edge (for registered decode)
//   wrap       count is at TOTAL-1 and is advancing this edge
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL = 800
) (
   input  logic               clk50M,
   input  logic               reset,
   input  logic               en,
   output logic [COORD_W-1:0] count,
   output logic [COORD_W-1:0] count_next,
   output logic               wrap
);

   localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

   logic [COORD_W-1:0] count_q;
   logic [COORD_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk50M) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count      = count_q;
   assign count_next = count_d;
   assign wrap       = en && (count_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA raster timing generator running on the 50 MHz system clock with an
// internal divide-by-2 pixel enable. Produces sync pulses, a visible-area flag,
// pixel coordinates and a frame-start marker for the renderer.
//   clk50M  system clock, the only clock
//   reset   synchronous, active-high
//   vga     master side of vga_sync_gen_if (all outputs registered)
// -----------------------------------------------------------------------------
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_DISPLAY   = H_DISPLAY_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BACK      = H_BACK_DEF,
   parameter int   V_DISPLAY   = V_DISPLAY_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BACK      = V_BACK_DEF,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic             clk50M,
   input  logic             reset,
   vga_sync_gen_if.master   vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_DISPLAY);
   localparam logic [COORD_W-1:0] H_SYNC_LO  = COORD_W'(H_DISPLAY + H_FRONT);
   localparam logic [COORD_W-1:0] H_SYNC_HI  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] V_SYNC_LO  = COORD_W'(V_DISPLAY + V_FRONT);
   localparam logic [COORD_W-1:0] V_SYNC_HI  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic               p_tick_q, p_tick_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               video_on_q, video_on_d;
   logic               frame_start_q, frame_start_d;

   logic [COORD_W-1:0] x_cnt, x_next;
   logic [COORD_W-1:0] y_cnt, y_next;
   logic               h_wrap, v_wrap;

   // Horizontal axis advances on the registered pixel enable.
   vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
      .clk50M     (clk50M),
      .reset      (reset),
      .en         (p_tick_q),
      .count      (x_cnt),
      .count_next (x_next),
      .wrap       (h_wrap)
   );

   // Vertical axis advances once per line, on the same edge as the H wrap.
   vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
      .clk50M     (clk50M),
      .reset      (reset),
      .en         (h_wrap),
      .count      (y_cnt),
      .count_next (y_next),
      .wrap       (v_wrap)
   );

   always_comb begin
      p_tick_d    = ~p_tick_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      video_on_d  = video_on_q;
      // Decode only when the counters move, so the flags stay aligned with
      // the coordinates (including the reset-release (0,0) with video_on=0).
      if (p_tick_q) begin
         hsync_d    = in_range(x_next, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync_d    = in_range(y_next, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on_d = (x_next < H_VIS) && (y_next < V_VIS);
      end
      // v_wrap already implies h_wrap and p_tick, so this is a single-cycle pulse.
      frame_start_d = v_wrap;
   end

   always_ff @(posedge clk50M) begin
      if (reset) begin
         p_tick_q      <= 1'b0;
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         p_tick_q      <= p_tick_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.p_tick      = p_tick_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = video_on_q;
   assign vga.pixel_x     = x_cnt;
   assign vga.pixel_y     = y_cnt;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed checks of the raster generator. Instance A uses the default
// 640x480 timing (line-level behaviour); instance B uses a tiny 15x8 raster
// with active-high syncs so whole frames, the wrap corner and a mid-frame
// reset fit in a short run.
//   B timing: H 8+2+3+2 = 15 (hsync x in [10,12]), V 4+1+2+1 = 8 (vsync y in [5,6]),
//   one frame = 15*8*2 = 240 clocks.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   int n_vec = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   vga_sync_gen_if a_if ();
   vga_sync_gen_if b_if ();

   vga_sync_gen dut_a (
      .clk50M (clk),
      .reset  (rst_a),
      .vga    (a_if)
   );

   vga_sync_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_ACTIVE(1'b1)
   ) dut_b (
      .clk50M (clk),
      .reset  (rst_b),
      .vga    (b_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) begin
         $display("vec %0d %s: %0d", n_vec, tag, obs);
      end else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fall1, fall2, rise1, voff_k, voff_x;
      int fs_early, fs_win, vis_win, hs_rise, vs_cyc;
      logic prev_h, prev_vid;

      // ---------------- reset state, both instances ----------------
      step(); step(); step();
      check("a_rst_p_tick",   a_if.p_tick, 0);
      check("a_rst_x",        a_if.pixel_x, 0);
      check("a_rst_y",        a_if.pixel_y, 0);
      check("a_rst_video_on", a_if.video_on, 0);
      check("a_rst_fs",       a_if.frame_start, 0);
      check("a_rst_hsync",    a_if.hsync, 1);
      check("a_rst_vsync",    a_if.vsync, 1);
      check("b_rst_hsync",    b_if.hsync, 0);
      check("b_rst_vsync",    b_if.vsync, 0);

      // ---------------- instance A: start-up and line timing ----------------
      rst_a = 1'b0;
      fall1 = -1; fall2 = -1; rise1 = -1; voff_k = -1; voff_x = -1;
      prev_h = a_if.hsync;
      prev_vid = a_if.video_on;
      for (int k = 1; k <= 3300; k++) begin
         step();
         if (k <= 6) begin
            check($sformatf("a_p_tick_e%0d", k), a_if.p_tick, k % 2);
            check($sformatf("a_x_e%0d", k), a_if.pixel_x, k / 2);
         end
         if (k == 1) check("a_vid_e1", a_if.video_on, 0);
         if (k == 2) check("a_vid_e2", a_if.video_on, 1);
         if (k == 1600) begin
            check("a_line1_x", a_if.pixel_x, 0);
            check("a_line1_y", a_if.pixel_y, 1);
            check("a_line1_vid", a_if.video_on, 1);
         end
         if (prev_h && !a_if.hsync) begin
            if (fall1 < 0) fall1 = k;
            else if (fall2 < 0) fall2 = k;
         end
         if (!prev_h && a_if.hsync && fall1 >= 0 && rise1 < 0) rise1 = k;
         if (prev_vid && !a_if.video_on && voff_k < 0) begin
            voff_k = k;
            voff_x = int'(a_if.pixel_x);
         end
         prev_h = a_if.hsync;
         prev_vid = a_if.video_on;
      end
      check("a_hsync_first_fall", fall1, 1312);
      check("a_hsync_period", fall2 - fall1, 1600);
      check("a_hsync_low_width", rise1 - fall1, 192);
      check("a_video_off_edge", voff_k, 1280);
      check("a_video_off_x", voff_x, 640);
      check("a_end_x", a_if.pixel_x, 50);
      check("a_end_y", a_if.pixel_y, 2);
      check("a_end_vsync", a_if.vsync, 1);

      // ---------------- instance B: two full frames ----------------
      rst_b = 1'b0;
      fs_early = 0; fs_win = 0; vis_win = 0; hs_rise = 0; vs_cyc = 0;
      prev_h = b_if.hsync;
      for (int k = 1; k <= 480; k++) begin
         step();
         if (k < 240 && b_if.frame_start) fs_early++;
         if (k == 239) begin
            check("b_pre_wrap_x", b_if.pixel_x, 14);
            check("b_pre_wrap_y", b_if.pixel_y, 7);
         end
         if (k == 240) begin
            check("b_wrap_x", b_if.pixel_x, 0);
            check("b_wrap_y", b_if.pixel_y, 0);
            check("b_wrap_fs", b_if.frame_start, 1);
            check("b_wrap_hsync", b_if.hsync, 0);
            check("b_wrap_vsync", b_if.vsync, 0);
            check("b_wrap_vid", b_if.video_on, 1);
         end
         if (k == 241) check("b_fs_width", b_if.frame_start, 0);
         if (k > 240) begin
            if (b_if.frame_start) fs_win++;
            if (b_if.video_on && b_if.p_tick) vis_win++;
            if (!prev_h && b_if.hsync) hs_rise++;
            if (b_if.vsync) vs_cyc++;
         end
         prev_h = b_if.hsync;
      end
      check("b_fs_before_first_wrap", fs_early, 0);
      check("b_fs_per_frame", fs_win, 1);
      check("b_visible_ticks", vis_win, 32);
      check("b_hsync_pulses", hs_rise, 8);
      check("b_vsync_cycles", vs_cyc, 60);

      // ---------------- instance B: reset mid-frame at (11,5) ----------------
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
      for (int k = 1; k <= 172; k++) step();
      check("b_mid_x", b_if.pixel_x, 11);
      check("b_mid_y", b_if.pixel_y, 5);
      check("b_mid_hsync", b_if.hsync, 1);
      check("b_mid_vsync", b_if.vsync, 1);
      rst_b = 1'b1;
      step();
      check("b_mrst_x", b_if.pixel_x, 0);
      check("b_mrst_y", b_if.pixel_y, 0);
      check("b_mrst_hsync", b_if.hsync, 0);
      check("b_mrst_vsync", b_if.vsync, 0);
      check("b_mrst_p_tick", b_if.p_tick, 0);
      check("b_mrst_vid", b_if.video_on, 0);
      rst_b = 1'b0;
      fs_early = 0;
      for (int k = 1; k <= 240; k++) begin
         step();
         if (k < 240 && b_if.frame_start) fs_early++;
         if (k == 240) check("b_resume_fs", b_if.frame_start, 1);
      end
      check("b_resume_no_early_fs", fs_early, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
